// File: rtl/cook_timer_pkg.sv
// Shared microwave definitions (package microwave_pkg): state encoding, BCD digit
// constants and the mm:ss one-second countdown helper used by cook_timer.
package microwave_pkg;

    localparam int BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_t;

    localparam bcd_t BCD_ZERO = 4'd0;
    localparam bcd_t BCD_FIVE = 4'd5;
    localparam bcd_t BCD_NINE = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_DONE  = 3'd3
    } state_t;

    typedef struct packed {
        bcd_t mmT;
        bcd_t mmU;
        bcd_t ssT;
        bcd_t ssU;
    } mmss_t;

    function automatic logic isZeroTime(input mmss_t t);
        return (t == '0);
    endfunction

    // Seconds borrow from minutes only once ss is 00, so keyed values like 01:90 drain naturally.
    function automatic mmss_t decSecond(input mmss_t t);
        mmss_t r;
        r = t;
        if (t.ssU != BCD_ZERO) begin
            r.ssU = t.ssU - 4'd1;
        end else if (t.ssT != BCD_ZERO) begin
            r.ssT = t.ssT - 4'd1;
            r.ssU = BCD_NINE;
        end else if ((t.mmT != BCD_ZERO) || (t.mmU != BCD_ZERO)) begin
            r.ssT = BCD_FIVE;
            r.ssU = BCD_NINE;
            if (t.mmU != BCD_ZERO) begin
                r.mmU = t.mmU - 4'd1;
            end else begin
                r.mmT = t.mmT - 4'd1;
                r.mmU = BCD_NINE;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cook_timer_if.sv
// Keypad/control inputs and display/status outputs of cook_timer.
// master = front-panel side, slave = the timer itself.
interface cook_timer_if;
    import microwave_pkg::*;

    logic       key_valid;
    bcd_t       key_digit;
    logic       start;
    logic       stop;
    logic       door_open;

    bcd_t       mm_t;
    bcd_t       mm_u;
    bcd_t       ss_t;
    bcd_t       ss_u;
    logic [2:0] state;
    logic       magnetron;
    logic       done;
    logic       beep;

    modport master (
        output key_valid, key_digit, start, stop, door_open,
        input  mm_t, mm_u, ss_t, ss_u, state, magnetron, done, beep
    );

    modport slave (
        input  key_valid, key_digit, start, stop, door_open,
        output mm_t, mm_u, ss_t, ss_u, state, magnetron, done, beep
    );

endinterface

// File: rtl/cook_timer_sec_tick_gen.sv
// One-second prescaler: counts 0..TICKS_PER_SEC-1 while enabled, holds otherwise,
// and flags the terminal-count cycle with a one-cycle tick.
module sec_tick_gen #(
    parameter int TICKS_PER_SEC = 100000000
) (
    input  logic Clk,
    input  logic Rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = $clog2(TICKS_PER_SEC);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] r_count;

    assign tick = en && !clr && (r_count == TERM);

    always_ff @(posedge Clk) begin
        if (Rst || clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= tick ? '0 : r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cook_timer.sv
// Microwave cook-time countdown: keyed BCD mm:ss, once-per-second decrement, magnetron/done/beep.
// Optional buzzer phase in DONE is enabled by defining COOK_TIMER_BEEP_EN.
module cook_timer
    import microwave_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100000000,
    parameter int BEEP_SECS     = 3
) (
    input  logic        Clk,
    input  logic        Rst,
    cook_timer_if.slave bus
);

    if ((TICKS_PER_SEC < 2) || (BEEP_SECS < 1)) begin : g_badParams
        $error("cook_timer: TICKS_PER_SEC must be >= 2 and BEEP_SECS >= 1");
    end

    state_t r_state, w_stateNext;
    mmss_t  r_time, w_timeNext, w_timeDec;
    logic   r_done, w_doneNext;
    logic   w_preClr, w_preEn, w_tick, w_anyExit;

    assign w_anyExit = bus.start || bus.stop || bus.door_open;
    assign w_timeDec = decSecond(r_time);
    assign w_preClr  = (r_state == ST_IDLE);

    // Stop or door in RUN freezes the prescaler that very cycle, so a due tick is dropped.
`ifdef COOK_TIMER_BEEP_EN
    assign w_preEn = ((r_state == ST_RUN) && !bus.stop && !bus.door_open) ||
                     ((r_state == ST_DONE) && !w_anyExit);
`else
    assign w_preEn = (r_state == ST_RUN) && !bus.stop && !bus.door_open;
`endif

    sec_tick_gen #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_secTick (
        .Clk  (Clk),
        .Rst  (Rst),
        .clr  (w_preClr),
        .en   (w_preEn),
        .tick (w_tick)
    );

`ifdef COOK_TIMER_BEEP_EN
    localparam int BEEP_W = $clog2(BEEP_SECS + 1);
    localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_SECS - 1);

    logic [BEEP_W-1:0] r_beepSecs, w_beepSecsNext;
    logic              r_beep;
`endif

    always_comb begin
        w_stateNext = r_state;
        w_timeNext  = r_time;
        w_doneNext  = 1'b0;
`ifdef COOK_TIMER_BEEP_EN
        w_beepSecsNext = '0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (bus.stop) begin
                    w_timeNext = '0;
                end else begin
                    if (bus.start && !bus.door_open && !isZeroTime(r_time)) begin
                        w_stateNext = ST_RUN;
                    end
                    if (bus.key_valid && (bus.key_digit <= BCD_NINE)) begin
                        w_timeNext = mmss_t'({r_time.mmU, r_time.ssT, r_time.ssU, bus.key_digit});
                    end
                end
            end
            ST_RUN: begin
                if (bus.stop || bus.door_open) begin
                    w_stateNext = ST_PAUSE;
                end else if (w_tick) begin
                    w_timeNext = w_timeDec;
                    if (isZeroTime(w_timeDec)) begin
                        w_stateNext = ST_DONE;
                        w_doneNext  = 1'b1;
                    end
                end
            end
            ST_PAUSE: begin
                if (bus.stop) begin
                    w_stateNext = ST_IDLE;
                    w_timeNext  = '0;
                end else if (bus.start && !bus.door_open) begin
                    w_stateNext = ST_RUN;
                end
            end
            ST_DONE: begin
                if (w_anyExit) begin
                    w_stateNext = ST_IDLE;
                end
`ifdef COOK_TIMER_BEEP_EN
                else begin
                    w_beepSecsNext = r_beepSecs;
                    if (w_tick) begin
                        if (r_beepSecs == BEEP_LAST) begin
                            w_stateNext = ST_IDLE;
                        end else begin
                            w_beepSecsNext = r_beepSecs + BEEP_W'(1);
                        end
                    end
                end
`endif
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= ST_IDLE;
            r_time  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_time  <= w_timeNext;
            r_done  <= w_doneNext;
        end
    end

`ifdef COOK_TIMER_BEEP_EN
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_beepSecs <= '0;
            r_beep     <= 1'b0;
        end else begin
            r_beepSecs <= w_beepSecsNext;
            r_beep     <= (w_stateNext == ST_DONE);
        end
    end

    assign bus.beep = r_beep;
`else
    assign bus.beep = 1'b0;
`endif

    assign bus.mm_t      = r_time.mmT;
    assign bus.mm_u      = r_time.mmU;
    assign bus.ss_t      = r_time.ssT;
    assign bus.ss_u      = r_time.ssU;
    assign bus.state     = r_state;
    assign bus.magnetron = (r_state == ST_RUN);
    assign bus.done      = r_done;

endmodule

// File: doc/cook_timer.md
Name: cook_timer

Overview:
- Microwave cook-time countdown: keypad digits shift into a BCD mm:ss register, then the block counts down once per second to 00:00.
- Complements the free-running up-counter used for system timing: the same clock-enable style, but the count is loaded and decremented.
- Drives the magnetron enable, the display digits and the end-of-cook signalling.
- Sits between the keypad decoder and the 7-segment display driver.

Parameters:
- TICKS_PER_SEC, 100000000, Clk cycles per one-second decrement (must be >= 2).
- BEEP_SECS, 3, seconds beep stays high in DONE (used only with COOK_TIMER_BEEP_EN).

Ports:
- Clk  in  1  system clock, all logic on posedge.
- Rst  in  1  synchronous active-high reset, sampled on posedge Clk.
- key_valid  in  1  one-cycle strobe; key_digit is valid.
- key_digit  in  4  BCD keypad digit; values 10-15 are ignored.
- start  in  1  one-cycle start/resume strobe.
- stop  in  1  one-cycle pause/clear strobe.
- door_open  in  1  level; 1 = door open.
- mm_t, mm_u, ss_t, ss_u  out  4 each  BCD display digits.
- state  out  3  current FSM state: IDLE=0, RUN=1, PAUSE=2, DONE=3.
- magnetron  out  1  high exactly while state==RUN.
- done  out  1  one-cycle pulse on entry to DONE.
- beep  out  1  buzzer drive.

Behaviour:
- Reset, which overrides every other input on the same edge:
  - state=IDLE.
  - All digits 0.
  - Prescaler 0.
  - magnetron=0, done=0, beep=0.
- Outputs are registered; state changes are visible on the edge after the strobe.
- IDLE:
  - key_valid with digit 0-9 shifts left: mm_t<=mm_u, mm_u<=ss_t, ss_t<=ss_u, ss_u<=key_digit.
  - Digits 10-15 are ignored.
  - ss_t may hold 6-9 (e.g. 01:90 is legal); it counts down naturally.
  - start with a nonzero time and door_open=0 -> RUN, prescaler cleared.
  - start with 00:00 or with the door open is ignored.
  - stop clears all digits to 0.
- RUN:
  - Prescaler counts 0..TICKS_PER_SEC-1.
  - At the terminal count, wrap to 0 and decrement one second, BCD with borrow:
    - ss_u 0 -> 9 with borrow into ss_t.
    - When ss reaches 00 and mm is nonzero, ss becomes 59 and mm decrements (mm_u 0 -> 9 with borrow into mm_t).
  - The decrement from 00:01 to 00:00 moves to DONE on the same edge, and done pulses on the next cycle.
  - First decrement occurs TICKS_PER_SEC cycles after the start edge.
  - stop -> PAUSE.
  - door_open=1 -> PAUSE; any tick due that cycle is suppressed.
  - key_valid is ignored.
- PAUSE:
  - Digits and prescaler are held.
  - start with door closed -> RUN; the prescaler resumes from its held value.
  - stop -> IDLE with digits cleared.
  - key_valid is ignored.
- DONE:
  - Digits stay 00:00.
  - start, stop or door_open -> IDLE.
  - key_valid is ignored.
- Simultaneous events:
  - stop wins over start.
  - In RUN, door_open wins over start.
  - key_valid together with start in IDLE: the digit shifts in and start is evaluated on the pre-shift value.
- Reset mid-RUN drops magnetron on the next edge with no done pulse.

Optional Feature:
- Macro: COOK_TIMER_BEEP_EN.
- Defined:
  - On entering DONE, beep=1 for BEEP_SECS*TICKS_PER_SEC cycles, counted by the reused prescaler.
  - beep then drops to 0 and the state auto-returns to IDLE.
  - start, stop or door_open in DONE ends the beep early and returns to IDLE.
- Undefined:
  - beep is tied to 0.
  - DONE is held until start, stop or door_open.
  - No beep counter logic is synthesised.

Decomposition:
- Shared package microwave_pkg holds:
  - The state encoding constants (IDLE/RUN/PAUSE/DONE).
  - The BCD digit width constant (4).
  - The shared BCD zero/nine constants.
- One sub-module, sec_tick_gen, with ports Clk, Rst, clr, en and tick:
  - Prescaler to TICKS_PER_SEC.
  - Hold when en=0.
  - One-cycle tick at the terminal count.

Test Plan (TICKS_PER_SEC=4, BEEP_SECS=2):
- Keys 1,3,0 then start -> display 01:30, RUN, magnetron=1; after 4 cycles 01:29; 00:59 follows 01:00.
- Keys 0,0,0,3 then start -> 00:02, 00:01, 00:00; DONE entered on the 00:01->00:00 edge, done pulses exactly once, magnetron=0.
- RUN at 00:05, door_open=1 for 10 cycles -> PAUSE, digits frozen at 00:05. Door closed, start -> RUN resumes; next decrement occurs after the remaining prescaler cycles.
- Start with 00:00 -> stays IDLE. stop+start in the same cycle in PAUSE -> IDLE with 00:00. key_digit=12 -> no shift.
- Keys 9,0 (00:90) then start -> 00:89 ... 00:60, 00:59 with no mm borrow.
- With COOK_TIMER_BEEP_EN: beep high for 8 cycles after DONE, then IDLE. Without: beep stays 0 and DONE holds until stop.
